// File: rtl/peripheral_pkg.sv
// Shared types and constants for the operand-entry / result-output peripherals.
// Byte indexing (byte k = bits [8k+7:8k]) is common to both sides.
package peripheral_pkg;

    localparam int BYTE_W = 8;
    localparam int IDX_W  = 4;
    localparam int GAP_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } put_state_e;

endpackage

// File: rtl/peripheral_putresult.sv
// Captures one result word and streams it LSB-first to an 8-bit valid/ready consumer,
// tagging each byte with its index and optionally idling GAP cycles between bytes.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; result sampled on the accepted start
// SEND  | byte cnt presented with outvalid, held until outready
// GAP   | idle spacing after a non-final byte, GAP cycles long
// FIN   | one-cycle done pulse, then back to IDLE
module peripheral_putresult
    import peripheral_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int GAP    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_W-1:0]    result,
    output logic [BYTE_W-1:0]    outdata,
    output logic                 outvalid,
    input  logic                 outready,
    output logic [IDX_W-1:0]     dataoutput_o,
    output logic                 busy,
    output logic                 done
);

    localparam int               NBYTES   = DATA_W / BYTE_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);

    put_state_e          state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                busy_q, busy_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d = result;
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (outready) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_FIN;
                    end else begin
                        cnt_d   = cnt_q + IDX_W'(1);
                        shift_d = shift_q >> BYTE_W;
                        if (GAP > 0) begin
                            gap_d   = GAP_LOAD;
                            state_d = ST_GAP;
                        end
                    end
                end
            end
            ST_GAP: begin
                // down-counter: leave on the cycle the terminal count is reached
                if (gap_q <= GAP_W'(1)) begin
                    gap_d   = '0;
                    state_d = ST_SEND;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_d = (state_d == ST_SEND) || (state_d == ST_GAP);

    always_comb begin
        outvalid     = (state_q == ST_SEND);
        outdata      = outvalid ? shift_q[BYTE_W-1:0] : '0;
        dataoutput_o = outvalid ? cnt_q : '0;
        done         = (state_q == ST_FIN);
        busy         = busy_q;
    end

endmodule

// File: tb/tb_peripheral_putresult.sv
// Directed bench for peripheral_putresult: a GAP=0 instance and a GAP=2 instance
// share stimulus; expected bytes and cycle positions are computed by hand.
module tb_peripheral_putresult;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] result;
    logic        outready;

    logic [7:0]  od0, odg;
    logic        ov0, ovg;
    logic [3:0]  ix0, ixg;
    logic        busy0, busyg;
    logic        done0, doneg;

    int n_checks = 0;
    int n_errors = 0;
    int hs0      = 0;

    peripheral_putresult #(.DATA_W(32), .GAP(0)) dut (
        .clk(clk), .reset(reset), .start(start), .result(result),
        .outdata(od0), .outvalid(ov0), .outready(outready),
        .dataoutput_o(ix0), .busy(busy0), .done(done0)
    );

    peripheral_putresult #(.DATA_W(32), .GAP(2)) dut_gap (
        .clk(clk), .reset(reset), .start(start), .result(result),
        .outdata(odg), .outvalid(ovg), .outready(outready),
        .dataoutput_o(ixg), .busy(busyg), .done(doneg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (ov0 && outready) hs0 <= hs0 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // GAP=0 transfer with outready high; optional stray starts during SEND and FIN
    task automatic xfer0(input logic [31:0] w, input bit inject);
        logic [31:0] word;
        word   = w;
        start  = 1'b1;
        result = word;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk("valid", {31'd0, ov0}, 32'd1);
            chk("byte", {24'd0, od0}, {24'd0, word[8*k +: 8]});
            chk("index", {28'd0, ix0}, k);
            chk("busy", {31'd0, busy0}, 32'd1);
            chk("done_early", {31'd0, done0}, 32'd0);
            if (inject && k == 1) begin
                start  = 1'b1;
                result = 32'hFFFF_FFFF;
            end
        end
        @(negedge clk);
        start = inject;
        chk("done", {31'd0, done0}, 32'd1);
        chk("fin_valid", {31'd0, ov0}, 32'd0);
        chk("fin_busy", {31'd0, busy0}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse", {31'd0, done0}, 32'd0);
        chk("idle_valid", {31'd0, ov0}, 32'd0);
        @(negedge clk);
        chk("no_restart", {31'd0, ov0}, 32'd0);
        chk("no_restart_busy", {31'd0, busy0}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hs_base;
        logic [31:0] gw;
        logic        ev;
        reset    = 1'b0;
        start    = 1'b0;
        result   = 32'd0;
        outready = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("rst_valid", {31'd0, ov0}, 32'd0);
        chk("rst_data", {24'd0, od0}, 32'd0);
        chk("rst_index", {28'd0, ix0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        idle(2);
        reset = 1'b0;
        idle(2);

        // basic back-to-back transfer
        xfer0(32'hDEAD_BEEF, 1'b0);
        idle(15);

        // backpressure on byte 1
        hs_base = hs0;
        start   = 1'b1;
        result  = 32'h1122_3344;
        @(negedge clk);
        start = 1'b0;
        chk("bp_b0", {24'd0, od0}, 32'h44);
        chk("bp_i0", {28'd0, ix0}, 32'd0);
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            outready = (c == 5);
            chk("bp_hold_valid", {31'd0, ov0}, 32'd1);
            chk("bp_hold_byte", {24'd0, od0}, 32'h33);
            chk("bp_hold_index", {28'd0, ix0}, 32'd1);
        end
        @(negedge clk);
        chk("bp_b2", {24'd0, od0}, 32'h22);
        chk("bp_i2", {28'd0, ix0}, 32'd2);
        @(negedge clk);
        chk("bp_b3", {24'd0, od0}, 32'h11);
        chk("bp_i3", {28'd0, ix0}, 32'd3);
        @(negedge clk);
        chk("bp_done", {31'd0, done0}, 32'd1);
        chk("bp_handshakes", hs0 - hs_base, 32'd4);
        idle(15);

        // gap instance: bytes at cycles 1,4,7,10; done at 11
        gw     = 32'hA1B2_C3D4;
        start  = 1'b1;
        result = gw;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            start = 1'b0;
            ev = (c <= 10) && (((c - 1) % 3) == 0);
            chk("gap_valid", {31'd0, ovg}, {31'd0, ev});
            if (ev) begin
                chk("gap_byte", {24'd0, odg}, {24'd0, gw[8*((c-1)/3) +: 8]});
                chk("gap_index", {28'd0, ixg}, (c - 1) / 3);
            end
            chk("gap_busy", {31'd0, busyg}, {31'd0, c <= 10});
            chk("gap_done", {31'd0, doneg}, {31'd0, c == 11});
        end
        idle(15);

        // stray starts during SEND and FIN are ignored
        xfer0(32'h0102_0304, 1'b1);
        idle(15);

        // asynchronous reset after byte 1 accepted
        start  = 1'b1;
        result = 32'hCAFE_F00D;
        @(negedge clk);
        start = 1'b0;
        chk("mr_b0", {24'd0, od0}, 32'h0D);
        @(negedge clk);
        chk("mr_b1", {24'd0, od0}, 32'hF0);
        @(negedge clk);
        chk("mr_b2_index", {28'd0, ix0}, 32'd2);
        #1 reset = 1'b1;
        #1;
        chk("mr_valid", {31'd0, ov0}, 32'd0);
        chk("mr_busy", {31'd0, busy0}, 32'd0);
        chk("mr_done", {31'd0, done0}, 32'd0);
        chk("mr_data", {24'd0, od0}, 32'd0);
        chk("mr_index", {28'd0, ix0}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        xfer0(32'h0000_0055, 1'b0);
        idle(15);

        // start together with reset
        reset  = 1'b1;
        start  = 1'b1;
        result = 32'h1234_5678;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("col_valid", {31'd0, ov0}, 32'd0);
        chk("col_busy", {31'd0, busy0}, 32'd0);
        @(negedge clk);
        chk("col_valid2", {31'd0, ov0}, 32'd0);
        chk("col_gap_valid", {31'd0, ovg}, 32'd0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/peripheral_putresult.md
Name: peripheral_putresult

Overview:
- Output-side counterpart of the operand-collection peripheral: captures one 32-bit result word and delivers it byte-by-byte to an 8-bit consumer (display/host port).
- Each byte is tagged with its byte index, using the same 0..3 indexing (byte k = bits [8k+7:8k]) as operand entry.
- Sits between the ALU result register and the board output path.
- Transfers use a valid/ready handshake, with optional idle gap cycles between bytes.

Parameters:
- DATA_W, 32, width of the result word; must be a multiple of 8.
- GAP, 0, idle cycles inserted after each accepted byte before the next byte is presented (0..255).
- NBYTES, DATA_W/8, localparam, number of bytes per word (not overridable).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to capture result and begin transfer; honoured only in IDLE.
- result  input  DATA_W  word to send; sampled on the accepted start cycle only.
- outdata  output  8  current byte.
- outvalid  output  1  outdata/dataoutput_o are valid.
- outready  input  1  consumer accepts the byte when outvalid && outready at a rising edge.
- dataoutput_o  output  4  index of the byte on outdata (0 = LSB).
- busy  output  1  high from the cycle after the accepted start until done.
- done  output  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (async, any state):
  - FSM → IDLE; shift register, byte counter and gap counter → 0.
  - outdata=0, outvalid=0, dataoutput_o=0, busy=0, done=0.
  - A transfer in flight is abandoned; no done pulse is generated.
- FSM states: IDLE, SEND, GAP, FIN.
- IDLE:
  - outvalid=0, busy=0.
  - start=1 → latch result into the internal register, byte counter=0, go to SEND.
- SEND:
  - outvalid=1; outdata = latched[8*cnt +: 8]; dataoutput_o = cnt.
  - outdata and dataoutput_o stay stable while outvalid && !outready.
  - On handshake with cnt < NBYTES-1: cnt+1, then go to GAP if GAP>0, else stay in SEND. With GAP=0, back-to-back bytes are possible, one per cycle.
  - On handshake with cnt = NBYTES-1: go to FIN; no gap after the final byte.
- GAP:
  - outvalid=0; count GAP cycles, then go to SEND.
  - The gap counter reloads on every entry to GAP.
- FIN:
  - done=1 for exactly one cycle, busy=0, outvalid=0; go to IDLE.
- Latency, GAP=0 with outready tied high:
  - start at cycle 0 → byte0 valid at cycle 1, byte3 at cycle 4, done at cycle 5.
  - A new start is accepted no earlier than cycle 6, i.e. the first IDLE cycle.
- start while busy or in FIN is ignored; the latched word is unchanged, so changes on result during a transfer have no effect.
- start and reset asserted together: reset wins.
- outready while outvalid=0 is ignored.
- busy is registered; it equals (state==SEND || state==GAP).
- The byte counter never exceeds NBYTES-1; dataoutput_o upper bits are 0 when NBYTES<16.
- All outputs are registered or decoded from registered state; there is no combinational path from outready to outvalid.

Decomposition:
- Shared package peripheral_pkg:
  - FSM state enum (IDLE, SEND, GAP, FIN).
  - BYTE_W=8.
  - Byte-index width constant IDX_W=4, shared with operand entry.
- Sub-module: none required. The gap counter is inlined; if reused elsewhere, extract it as peripheral_gapcnt (load/decrement/zero flag).

Test Plan:
- Basic, GAP=0, outready=1: reset; start with result=32'hDEADBEEF → outdata EF,BE,AD,DE on consecutive cycles with dataoutput_o 0,1,2,3; done pulse on the cycle after byte 3; busy high across the 4 byte cycles.
- Backpressure: result=32'h11223344, outready low for 3 cycles on byte1 → outdata holds 8'h33 and dataoutput_o holds 1 with outvalid=1 throughout; resumes with 22,11 after outready rises; exactly 4 handshakes total.
- Gap: GAP=2, outready=1, result=32'hA1B2C3D4 → D4, 2 cycles outvalid=0, C3, 2 idle, B2, 2 idle, A1, done; total 11 cycles from start to done.
- Ignored start: during a transfer of 32'h01020304, pulse start with result=32'hFFFFFFFF → output sequence stays 04,03,02,01; no second transfer begins after done unless start is reasserted in IDLE.
- Mid-transfer reset: assert reset after byte1 is accepted → outvalid, busy, done, outdata and dataoutput_o all 0 immediately (asynchronous); after release, start with 32'h00000055 → sends 55,00,00,00 from index 0.
- Start/reset collision: start=1 in the same cycle reset deasserts-to-asserted → remains IDLE, no outvalid.
